// File: rtl/apb3_requester_arbiter_if.sv
// APB3 bus bundle between the requester arbiter (master) and the shared completer (slave).
interface apb3_requester_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_requester_arbiter.sv
// Round-robin arbiter sharing one APB3 completer among NUM_REQ single-beat requesters.
// Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer; req_ready offered to the round-robin winner
// SETUP  | APB setup phase, PSEL=1 PENABLE=0 for one cycle
// ACCESS | APB access phase, PSEL=1 PENABLE=1, waiting on PREADY
module apb3_requester_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  apb3_requester_arbiter_if.master      apb
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  grant_next;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // unpack the flat per-requester buses into indexable arrays
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // first valid requester at or above rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    logic [SUM_W-1:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(off);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      if (!found && req_valid[sum[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDX_W-1:0];
      end
    end
  end

  // accept only the winner, and only while idle
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign grant_next = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // APB phase sequencing, request capture and one-cycle response pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= winner;
            apb.PADDR  <= addr_arr[winner];
            apb.PWRITE <= req_write[winner];
            apb.PWDATA <= wdata_arr[winner];
            apb.PSEL   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        ACCESS: begin
          if (apb.PREADY) begin
            // writes leave the last read data in place
            if (!apb.PWRITE) rsp_rdata <= apb.PRDATA;
            rsp_err          <= apb.PSLVERR;
            rsp_valid[grant] <= 1'b1;
            apb.PSEL         <= 1'b0;
            apb.PENABLE      <= 1'b0;
            rr_ptr           <= grant_next;
            state            <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
            rsp_valid[grant] <= 1'b1;
            apb.PSEL         <= 1'b0;
            apb.PENABLE      <= 1'b0;
            rr_ptr           <= grant_next;
            state            <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb3_requester_arbiter.sv
// Directed bench for apb3_requester_arbiter with a small APB RAM completer model.
module tb_apb3_requester_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic [NREQ-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;

  apb3_requester_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb3_requester_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(bus)
  );

  always #5 PCLK = ~PCLK;

  // completer model: RAM, PREADY after wait_cycles ACCESS cycles, PSLVERR at 0x40
  logic [31:0] mem [0:255];
  int acc_cnt;
  int wait_cycles;

  assign bus.PREADY  = (acc_cnt >= wait_cycles);
  assign bus.PRDATA  = mem[bus.PADDR[7:0]];
  assign bus.PSLVERR = (bus.PADDR == 32'h40);

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc_cnt <= 0;
      for (int i = 0; i < 256; i++)
        mem[i] <= (i >= 32 && i < 36) ? 32'h1000 + 32'(i - 32) : 32'h0;
    end else begin
      if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
        mem[bus.PADDR[7:0]] <= bus.PWDATA;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = d;
    req_write[idx]          = wr;
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nwait;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  // one isolated transfer; entered and left at a negedge with the DUT idle
  task automatic run_vec(input vec_t v, input int n);
    logic [NREQ-1:0] oh;
    oh = onehot(v.idx);
    wait_cycles = v.nwait;
    set_req(v.idx, v.wr, v.addr, v.wdata);
    req_valid = oh;
    #1;
    chk($sformatf("v%0d ready", n), req_ready, oh);
    @(posedge PCLK); #1;
    req_valid = '0;
    @(negedge PCLK);
    chk($sformatf("v%0d setup sel/en", n), {bus.PSEL, bus.PENABLE}, 2'b10);
    chk($sformatf("v%0d setup paddr", n), bus.PADDR, v.addr);
    chk($sformatf("v%0d setup pwrite", n), bus.PWRITE, v.wr);
    if (v.wr) chk($sformatf("v%0d setup pwdata", n), bus.PWDATA, v.wdata);
    @(negedge PCLK);
    chk($sformatf("v%0d access sel/en", n), {bus.PSEL, bus.PENABLE}, 2'b11);
    chk($sformatf("v%0d access rsp_valid", n), rsp_valid, '0);
    for (int k = 0; k < v.nwait; k++) begin
      @(negedge PCLK);
      chk($sformatf("v%0d wait%0d sel/en", n, k), {bus.PSEL, bus.PENABLE}, 2'b11);
      chk($sformatf("v%0d wait%0d paddr", n, k), bus.PADDR, v.addr);
      if (v.wr) chk($sformatf("v%0d wait%0d pwdata", n, k), bus.PWDATA, v.wdata);
      chk($sformatf("v%0d wait%0d rsp_valid", n, k), rsp_valid, '0);
    end
    @(negedge PCLK);
    chk($sformatf("v%0d rsp_valid", n), rsp_valid, oh);
    chk($sformatf("v%0d rsp_rdata", n), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", n), rsp_err, v.exp_err);
    chk($sformatf("v%0d psel dropped", n), {bus.PSEL, bus.PENABLE}, 2'b00);
    @(negedge PCLK);
    chk($sformatf("v%0d rsp pulse end", n), rsp_valid, '0);
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    PRESETn     = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    wait_cycles = 0;

    //            idx wr    addr    wdata          wait exp_rdata      err
    vecs[0] = '{0, 1'b1, 32'h05, 32'hDEADBEEF, 0, 32'h00000000, 1'b0};
    vecs[1] = '{0, 1'b0, 32'h05, 32'h00000000, 0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{2, 1'b1, 32'h10, 32'h12345678, 3, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1, 1'b0, 32'h10, 32'h00000000, 1, 32'h12345678, 1'b0};
    vecs[4] = '{3, 1'b0, 32'h40, 32'h00000000, 0, 32'h00000000, 1'b1};
    vecs[5] = '{3, 1'b1, 32'h40, 32'hA5A5A5A5, 2, 32'h00000000, 1'b1};
    vecs[6] = '{2, 1'b0, 32'h05, 32'h00000000, 0, 32'hDEADBEEF, 1'b0};

    repeat (3) @(negedge PCLK);
    chk("reset psel/penable", {bus.PSEL, bus.PENABLE}, 2'b00);
    chk("reset pwrite", bus.PWRITE, 1'b0);
    chk("reset paddr", bus.PADDR, 32'h0);
    chk("reset pwdata", bus.PWDATA, 32'h0);
    chk("reset rsp_valid", rsp_valid, '0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", rsp_err, 1'b0);
    chk("reset req_ready", req_ready, '0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

    // reset in the middle of ACCESS; pointer is 3 beforehand
    wait_cycles = 100;
    set_req(1, 1'b0, 32'h07, 32'h0);
    req_valid = onehot(1);
    @(posedge PCLK); #1;
    req_valid = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("midreset pre sel/en", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("midreset sel/en", {bus.PSEL, bus.PENABLE}, 2'b00);
    chk("midreset rsp_valid", rsp_valid, '0);
    @(negedge PCLK);
    chk("midreset held rsp_valid", rsp_valid, '0);
    wait_cycles = 0;
    PRESETn = 1'b1;

    // round robin, all four reading continuously; pointer restarts at 0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h20 + 32'(i), 32'h0);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d grant", k), req_ready, onehot(rr_exp[k]));
      if (k > 0) begin
        chk($sformatf("rr%0d rsp_valid", k), rsp_valid, onehot(rr_exp[k-1]));
        chk($sformatf("rr%0d rsp_rdata", k), rsp_rdata, 32'h1000 + 32'(rr_exp[k-1]));
      end
      repeat (3) @(negedge PCLK);
    end
    #1;
    chk("rr last rsp_valid", rsp_valid, onehot(0));
    chk("rr last rsp_rdata", rsp_rdata, 32'h1000);
    req_valid = '0;
    @(negedge PCLK);
    chk("rr idle psel", bus.PSEL, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
    wait_cycles = 1000;
    set_req(0, 1'b0, 32'h09, 32'h0);
    req_valid = onehot(0);
    @(posedge PCLK); #1;
    req_valid = '0;
    @(negedge PCLK);
    chk("to setup sel/en", {bus.PSEL, bus.PENABLE}, 2'b10);
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      chk($sformatf("to access%0d", k), {bus.PSEL, bus.PENABLE, rsp_valid}, {2'b11, 4'b0000});
    end
    @(negedge PCLK);
    chk("to rsp_valid", rsp_valid, onehot(0));
    chk("to rsp_err", rsp_err, 1'b1);
    chk("to rsp_rdata", rsp_rdata, 32'h0);
    chk("to sel/en", {bus.PSEL, bus.PENABLE}, 2'b00);
    wait_cycles = 0;
    @(negedge PCLK);
    chk("to pulse end", rsp_valid, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb3_requester_arbiter.md
Name: apb3_requester_arbiter

Overview:
- Shares one APB3 completer (the memory-backed APB RAM) among NUM_REQ requesters.
- Each requester issues a single-beat read/write on a valid/ready command port and gets a one-cycle response pulse.
- The block arbitrates round-robin, sequences the APB3 SETUP/ACCESS phases, waits on PREADY and routes PRDATA/PSLVERR back to the winner.
- It sits between the requesters and the completer's PSEL/PENABLE/PADDR/PWRITE/PWDATA inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with the optional feature.

Ports:
- PCLK  input  1  clock, rising edge.
- PRESETn  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_ready  output  NUM_REQ  per-requester command accept.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  output  NUM_REQ  one-cycle response pulse to the owning requester.
- rsp_rdata  output  DATA_WIDTH  read data, shared; valid only while any rsp_valid bit is high.
- rsp_err  output  1  error flag, qualified by rsp_valid.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PADDR  output  ADDR_WIDTH  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESETn is asynchronous and active-low.
- Reset values (applied immediately on PRESETn low):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - RR pointer = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Winner = first set req_valid bit searching from the RR pointer upward, wrapping at NUM_REQ-1 -> 0.
  - req_ready[winner] = 1 combinationally. All other req_ready bits are 0, and all are 0 outside IDLE.
  - On handshake, latch addr/write/wdata/grant index into PADDR/PWRITE/PWDATA registers; next state SETUP.
  - No request -> stay IDLE, PSEL = 0.
- SETUP: PSEL = 1, PENABLE = 0 for exactly one cycle; next state ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1; PADDR/PWRITE/PWDATA held stable.
  - PREADY = 0 -> stay; wait is unbounded unless the optional feature is enabled.
  - PREADY = 1 -> register PRDATA (reads only; writes leave rsp_rdata unchanged) and PSLVERR into rsp_rdata/rsp_err.
  - On the same edge: pulse rsp_valid[grant] for the next cycle, drop PSEL/PENABLE, set RR pointer = grant+1 mod NUM_REQ, return to IDLE.
- Latency: handshake at edge T -> SETUP in cycle T+1 -> ACCESS in cycle T+2. With PREADY high in the first ACCESS cycle, rsp_valid is high in cycle T+3. A new handshake can also occur in cycle T+3, giving a 3-cycle minimum per transfer.
- Simultaneous events:
  - A requester with rsp_valid high may hold req_valid; it is only granted if it is first from the new pointer.
  - A requester dropping req_valid before being accepted is legal; no transfer is issued.
- Fairness: every continuously-requesting requester is served within NUM_REQ transfers.
- Reset mid-transfer: the transfer is abandoned, no rsp_valid is produced and PSEL drops immediately.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0. When it reaches TIMEOUT_CYCLES:
  - The block leaves ACCESS and drops PSEL/PENABLE.
  - It pulses rsp_valid[grant] with rsp_err = 1 and rsp_rdata = 0, then returns to IDLE.
  - The RR pointer advances as for a normal completion.
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write then read, requester 0: write addr 0x5 data 0xDEADBEEF, then read addr 0x5 -> PSEL at T+1, PENABLE at T+2, rsp_valid[0] at T+3 both times; read gives rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Round-robin: all four req_valid held high with reads -> grant order 0,1,2,3,0; pointer wraps from 3 to 0.
- Wait states: completer holds PREADY low 3 cycles -> ACCESS lasts 4 cycles; PADDR/PWDATA stable throughout; single rsp_valid pulse.
- Error propagation: read addr 0x40 with completer returning PSLVERR = 1 -> rsp_err = 1 on rsp_valid of the issuing requester.
- Reset during ACCESS: assert PRESETn low mid-ACCESS -> PSEL/PENABLE/rsp_valid = 0 immediately; after release a new request is granted from requester 0.
- With APB_ARB_TIMEOUT_EN: PREADY held low forever -> after 16 ACCESS cycles rsp_valid pulses with rsp_err = 1, rsp_rdata = 0, state IDLE.
